// File: rtl/ctr_feistel_pkg.sv
// Shared constants, half-block type and latency helper for the CTR-mode Feistel cipher.
package ctr_feistel_pkg;

    localparam int SBOX_DEPTH = 256;
    localparam int HALF_WIDTH = 128;
    localparam int F_ROT      = 8;

    typedef logic [HALF_WIDTH-1:0] half_t;

    // Cycles from an accepted block to its ciphertext: counter register,
    // ROUND F pipelines, output register.
    function automatic int cipher_latency(input int rounds, input int f_lat);
        return rounds * f_lat + 2;
    endfunction

endpackage

// File: rtl/feistel_f_func.sv
// Pipelined Feistel round function F(R,K): key mix, byte substitution, rotate-left-8, delay.
// The S-box lives in the top; this block drives one lookup address per byte and takes the data back.
module feistel_f_func
    import ctr_feistel_pkg::*;
#(
    parameter int F_LAT    = 6,
    parameter int KEY_SIZE = 128
) (
    input  logic                clk,
    input  logic [KEY_SIZE-1:0] r,
    input  logic [KEY_SIZE-1:0] k,
    output logic [KEY_SIZE-1:0] sbox_addr,
    input  logic [KEY_SIZE-1:0] sbox_data,
    output logic [KEY_SIZE-1:0] f
);

    logic [KEY_SIZE-1:0] x_reg;
    logic [KEY_SIZE-1:0] s_reg;
    logic [KEY_SIZE-1:0] rot_reg;

    // Pure datapath: validity is tracked by the top, so no reset here.
    always_ff @(posedge clk) begin
        x_reg   <= r ^ k;
        s_reg   <= sbox_data;
        rot_reg <= {s_reg[KEY_SIZE-F_ROT-1:0], s_reg[KEY_SIZE-1 -: F_ROT]};
    end

    // Each byte of x_reg is a lookup address; substituted bytes come back in place.
    assign sbox_addr = x_reg;

    generate
        if (F_LAT > 3) begin : g_delay
            logic [KEY_SIZE-1:0] dly_reg [F_LAT-3];

            always_ff @(posedge clk) begin
                dly_reg[0] <= rot_reg;
                for (int i = 1; i < F_LAT-3; i++) begin
                    dly_reg[i] <= dly_reg[i-1];
                end
            end

            assign f = dly_reg[F_LAT-4];
        end else begin : g_no_delay
            assign f = rot_reg;
        end
    endgenerate

endmodule

// File: rtl/ctr_feistel_encrypt.sv
// Fully pipelined CTR-mode Feistel cipher with runtime-loaded S-box and round keys.
// Optional macro CTR_FEISTEL_LOAD_GATE_EN: hold off data until both tables are loaded, adds ready.
module ctr_feistel_encrypt
    import ctr_feistel_pkg::*;
#(
    parameter int ROUND      = 5,
    parameter int F_LAT      = 6,
    parameter int SBOX_WIDTH = 8,
    parameter int KEY_SIZE   = 128,
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sbox_valid,
    input  logic [SBOX_WIDTH-1:0] sbox_out,
    input  logic                  key_tvalid,
    input  logic [KEY_SIZE-1:0]   key,
    input  logic                  tvalid,
    input  logic [DATA_WIDTH-1:0] plaintext,
    input  logic [DATA_WIDTH-1:0] iv,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] ciphertext
`ifdef CTR_FEISTEL_LOAD_GATE_EN
    ,
    output logic                  ready
`endif
);

    localparam int LAT      = cipher_latency(ROUND, F_LAT);
    localparam int N_LOOKUP = KEY_SIZE / SBOX_WIDTH;
    localparam int KIDX_W   = (ROUND > 1) ? $clog2(ROUND) : 1;

    logic [SBOX_WIDTH-1:0] sbox_mem [2**SBOX_WIDTH];
    logic [KEY_SIZE-1:0]   key_mem  [ROUND];

    logic [SBOX_WIDTH-1:0] sbox_addr_reg;
    logic [KIDX_W-1:0]     key_idx_reg;
    logic [DATA_WIDTH-1:0] cnt_reg;
    logic [DATA_WIDTH-1:0] ctr_blk_reg;
    logic                  accept;

    logic [LAT-2:0]        v_pipe_reg;
    logic [DATA_WIDTH-1:0] pt_pipe_reg [LAT-1];
    logic [DATA_WIDTH-1:0] round_in [ROUND+1];

    // Table contents survive reset; only the write pointers are cleared.
    always_ff @(posedge clk) begin
        if (sbox_valid) sbox_mem[sbox_addr_reg] <= sbox_out;
        if (key_tvalid) key_mem[key_idx_reg]    <= key;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sbox_addr_reg <= '0;
            key_idx_reg   <= '0;
            cnt_reg       <= '0;
        end else begin
            if (sbox_valid) sbox_addr_reg <= sbox_addr_reg + SBOX_WIDTH'(1);
            if (key_tvalid) begin
                key_idx_reg <= (key_idx_reg == KIDX_W'(ROUND-1)) ? '0 : key_idx_reg + KIDX_W'(1);
            end
            if (accept) cnt_reg <= cnt_reg + DATA_WIDTH'(1);
        end
    end

`ifdef CTR_FEISTEL_LOAD_GATE_EN
    logic sbox_done_reg;
    logic key_done_reg;

    // Pointers restart at 0 on reset, so writing the last slot means a full load.
    always_ff @(posedge clk) begin
        if (reset) begin
            sbox_done_reg <= 1'b0;
            key_done_reg  <= 1'b0;
        end else begin
            if (sbox_valid && (sbox_addr_reg == '1)) sbox_done_reg <= 1'b1;
            if (key_tvalid && (key_idx_reg == KIDX_W'(ROUND-1))) key_done_reg <= 1'b1;
        end
    end

    assign ready  = sbox_done_reg & key_done_reg;
    assign accept = tvalid & ready;
`else
    assign accept = tvalid;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            v_pipe_reg <= '0;
        end else begin
            v_pipe_reg <= {v_pipe_reg[LAT-3:0], accept};
        end
    end

    always_ff @(posedge clk) begin
        ctr_blk_reg    <= iv + cnt_reg;
        pt_pipe_reg[0] <= plaintext;
        for (int i = 1; i < LAT-1; i++) begin
            pt_pipe_reg[i] <= pt_pipe_reg[i-1];
        end
    end

    assign round_in[0] = ctr_blk_reg;

    genvar gi, gj;
    generate
        for (gi = 0; gi < ROUND; gi++) begin : g_round
            logic [DATA_WIDTH-1:0] dly_reg [F_LAT];
            logic [KEY_SIZE-1:0]   lookup_addr;
            logic [KEY_SIZE-1:0]   lookup_data;
            logic [KEY_SIZE-1:0]   f_out;

            feistel_f_func #(
                .F_LAT    (F_LAT),
                .KEY_SIZE (KEY_SIZE)
            ) u_f (
                .clk       (clk),
                .r         (round_in[gi][KEY_SIZE-1:0]),
                .k         (key_mem[gi]),
                .sbox_addr (lookup_addr),
                .sbox_data (lookup_data),
                .f         (f_out)
            );

            for (gj = 0; gj < N_LOOKUP; gj++) begin : g_lookup
                assign lookup_data[gj*SBOX_WIDTH +: SBOX_WIDTH] =
                    sbox_mem[lookup_addr[gj*SBOX_WIDTH +: SBOX_WIDTH]];
            end

            // L and R ride alongside F so they meet its result at the round boundary.
            always_ff @(posedge clk) begin
                dly_reg[0] <= round_in[gi];
                for (int i = 1; i < F_LAT; i++) begin
                    dly_reg[i] <= dly_reg[i-1];
                end
            end

            assign round_in[gi+1] = {dly_reg[F_LAT-1][KEY_SIZE-1:0],
                                     dly_reg[F_LAT-1][DATA_WIDTH-1:KEY_SIZE] ^ f_out};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            valid      <= 1'b0;
            ciphertext <= '0;
        end else begin
            valid <= v_pipe_reg[LAT-2];
            if (v_pipe_reg[LAT-2]) ciphertext <= round_in[ROUND] ^ pt_pipe_reg[LAT-2];
        end
    end

endmodule

// File: tb/tb_ctr_feistel_encrypt.sv
// Scoreboard bench for ctr_feistel_encrypt: directed blocks, queue of expected ciphertexts.
// Honours CTR_FEISTEL_LOAD_GATE_EN when the design is built with it.
module tb_ctr_feistel_encrypt;
    import ctr_feistel_pkg::*;

    localparam int EXP_LAT = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sbox_valid = 1'b0;
    logic [7:0]   sbox_out = '0;
    logic         key_tvalid = 1'b0;
    logic [127:0] key = '0;
    logic         tvalid = 1'b0;
    logic [255:0] plaintext = '0;
    logic [255:0] iv = '0;
    logic         valid;
    logic [255:0] ciphertext;
`ifdef CTR_FEISTEL_LOAD_GATE_EN
    logic         ready;
`endif

    always #5 clk = ~clk;

    ctr_feistel_encrypt #(
        .ROUND(5), .F_LAT(6), .SBOX_WIDTH(8), .KEY_SIZE(128), .DATA_WIDTH(256)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sbox_valid (sbox_valid),
        .sbox_out   (sbox_out),
        .key_tvalid (key_tvalid),
        .key        (key),
        .tvalid     (tvalid),
        .plaintext  (plaintext),
        .iv         (iv),
        .valid      (valid),
        .ciphertext (ciphertext)
`ifdef CTR_FEISTEL_LOAD_GATE_EN
        ,
        .ready      (ready)
`endif
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [255:0] ct;
        int           cyc;
        string        name;
    } exp_t;

    exp_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;

    logic [7:0]   m_sbox [SBOX_DEPTH];
    half_t        m_key  [5];
    logic [255:0] m_cnt = '0;

    // Reference cipher written straight from the algorithm description.
    function automatic half_t m_f(input half_t r, input half_t k);
        half_t x, s;
        x = r ^ k;
        for (int b = 0; b < 16; b++) s[b*8 +: 8] = m_sbox[x[b*8 +: 8]];
        return {s[119:0], s[127:120]};
    endfunction

    function automatic logic [255:0] m_enc(input logic [255:0] c);
        half_t l, r, t;
        l = c[255:128];
        r = c[127:0];
        for (int i = 0; i < 5; i++) begin
            t = l ^ m_f(r, m_key[i]);
            l = r;
            r = t;
        end
        return {l, r};
    endfunction

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_sbox(input int mode);
        logic [7:0] v;
        for (int a = 0; a < 256; a++) begin
            v = (mode == 0) ? ~8'(a) : (mode == 1) ? 8'(a) : 8'(a * 7 + 3);
            sbox_valid = 1'b1;
            sbox_out   = v;
            m_sbox[a]  = v;
            tick();
        end
        sbox_valid = 1'b0;
    endtask

    task automatic load_keys(input int mode);
        half_t kv;
        for (int i = 0; i < 5; i++) begin
            kv = '0;
            if (mode == 1) begin
                for (int b = 0; b < 16; b++) kv[127-8*b -: 8] = {4'(i), 4'(b)};
            end
            key_tvalid = 1'b1;
            key        = kv;
            m_key[i]   = kv;
            tick();
        end
        key_tvalid = 1'b0;
    endtask

`ifdef CTR_FEISTEL_LOAD_GATE_EN
    task automatic reload();
        for (int a = 0; a < 256; a++) begin
            sbox_valid = 1'b1;
            sbox_out   = m_sbox[a];
            tick();
        end
        sbox_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            key_tvalid = 1'b1;
            key        = m_key[i];
            tick();
        end
        key_tvalid = 1'b0;
    endtask
`endif

    task automatic do_reset(input string nm);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_cnt = '0;
        chk({nm, "_valid"}, 256'(valid), 256'd0);
        chk({nm, "_ct"}, ciphertext, 256'd0);
`ifdef CTR_FEISTEL_LOAD_GATE_EN
        reload();
`endif
    endtask

    // kind 0: model expectation, 1: given expectation, 2: dropped in flight, 3: rejected
    task automatic send(input logic [255:0] pt, input logic [255:0] ivv, input int kind,
                        input logic [255:0] want, input string nm);
        exp_t e;
        tvalid    = 1'b1;
        plaintext = pt;
        iv        = ivv;
        if (kind <= 1) begin
            e.ct   = (kind == 0) ? (m_enc(ivv + m_cnt) ^ pt) : want;
            e.cyc  = cyc;
            e.name = nm;
            exp_q.push_back(e);
        end
        if (kind != 3) m_cnt = m_cnt + 256'd1;
        tick();
        tvalid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        repeat (4) tick();
        chk({nm, "_pending"}, 256'(exp_q.size()), 256'd0);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 256'(cyc), 256'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    $display("tx %s cycle %0d ct=%h", e.name, cyc, ciphertext);
                    chk({e.name, "_ct"}, ciphertext, e.ct);
                    chk({e.name, "_latency"}, 256'(cyc - e.cyc), 256'(EXP_LAT));
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [255:0] IV2 = 256'hAABBCCDD_EEFF0011_22334455_66778899_AABBCCDD_EEFF8899_00112233_44556677;
    localparam logic [255:0] PT1 = 256'h11223344_55667788_99AABBCC_DDEEFF00_11223344_55667788_99AABBCC_DDEEEEFF;
    localparam logic [255:0] PT2 = 256'hFFEEDDCC_BBAA9988_77665544_33221100_FFEEDDCC_BBAA9988_77665544_33226677;
    localparam logic [255:0] PT3 = 256'h01234567_89ABCDEF_FEDCBA98_76543210_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

    initial begin
        logic [255:0] ct_enc;
        fork
            monitor();
        join_none

        do_reset("rst0");
`ifdef CTR_FEISTEL_LOAD_GATE_EN
        // The reload inside do_reset completed loads; reset again to test the gate.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("gate_ready_rst", 256'(ready), 256'd0);
        send(PT1, 256'd0, 3, '0, "gate_early0");
        load_sbox(0);
        chk("gate_ready_sbox", 256'(ready), 256'd0);
        send(PT1, 256'd0, 3, '0, "gate_early1");
        load_keys(0);
        chk("gate_ready_both", 256'(ready), 256'd1);
`else
        load_sbox(0);
        load_keys(0);
`endif
        // Inverted S-box, zero keys, zero counter: rounds alternate to {ones, zeros}.
        send(256'd0, 256'd0, 1, {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd0}, "sbox_inv");
        drain("sbox_inv");

        // Identity S-box, zero keys, zero counter: keystream is zero, ct = pt.
        load_sbox(1);
        do_reset("rst1");
        send(PT3, 256'd0, 1, PT3, "sbox_ident");
        drain("sbox_ident");

        // Patterned keys, non-trivial S-box, two consecutive blocks.
        load_sbox(2);
        load_keys(1);
        do_reset("rst2");
        send(PT1, IV2, 0, '0, "b2b_0");
        send(PT2, IV2, 0, '0, "b2b_1");
        drain("b2b");

        // Counter wrap: second block must see counter block 0.
        do_reset("rst3");
        send(PT1, '1, 0, '0, "wrap_0");
        send(PT2, '1, 1, m_enc(256'd0) ^ PT2, "wrap_1");
        drain("wrap");

        // CTR involution: encrypting the ciphertext recovers the plaintext.
        do_reset("rst4");
        ct_enc = m_enc(IV2) ^ PT3;
        send(PT3, IV2, 0, '0, "inv_enc");
        drain("inv_enc");
        do_reset("rst5");
        send(ct_enc, IV2, 1, PT3, "inv_dec");
        drain("inv_dec");

        // Reset ten cycles after an accepted block: it must never appear.
        send(PT1, IV2, 2, '0, "dropped");
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_cnt = '0;
        chk("midrst_valid", 256'(valid), 256'd0);
`ifdef CTR_FEISTEL_LOAD_GATE_EN
        reload();
`endif
        repeat (40) tick();
        send(PT2, IV2, 1, m_enc(IV2) ^ PT2, "after_rst");
        drain("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
